// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the single-port RAM with clear engine.
package sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Where the visible read data comes from after the last update.
    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_MERGE = 2'd1,
        SRC_ZERO  = 2'd2
    } rd_src_t;

    localparam int RDW_OLD  = 0;
    localparam int RDW_NEW  = 1;
    localparam int RDW_HOLD = 2;

endpackage

// File: rtl/sp_ram_array.sv
// Storage only: byte-enable write port and a read-first registered read port.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // The read register samples the word before the write lands, so it yields the old word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[addr];
        end
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sp_ram_clr.sv
// Single-port RAM top: clear FSM, req/ready handshake, range check and read-during-write muxing.
module sp_ram_clr
    import sp_ram_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter int                RDW_MODE = RDW_OLD,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  clr,
    output logic                  ready,
    output logic                  busy,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                rvalid_q, rvalid_d;
    rd_src_t             src_q, src_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;

    logic                in_range;
    logic                rd_acc;
    logic                wr_acc;
    logic                arr_we;
    logic                arr_re;
    logic [BE_W-1:0]     arr_be;
    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [DATA_W-1:0]   arr_rdata;
    logic [DATA_W-1:0]   merged;

    assign ready    = (state_q == ST_RUN) && !clr;
    assign in_range = {1'b0, addr} < DEPTH_LIM;
    assign rd_acc   = req && ready && !we;
    assign wr_acc   = req && ready && we && in_range;

    // Array strobes are gated by rst so an asserted reset never disturbs the contents.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_be    = be;
        arr_addr  = addr;
        arr_wdata = wdata;
        if (state_q == ST_CLEAR) begin
            arr_we    = !rst;
            arr_be    = '1;
            arr_addr  = ptr_q;
            arr_wdata = CLR_VAL;
        end else begin
            arr_we = !rst && wr_acc;
            arr_re = !rst && ((rd_acc && in_range) || (wr_acc && RDW_MODE != RDW_HOLD));
        end
    end

    sp_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        rvalid_d = rd_acc;
        src_d    = src_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    ptr_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    ptr_d   = '0;
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        // A merged-word result keeps the write data around so the merge can be done after the array read.
        if (rd_acc) begin
            src_d = in_range ? SRC_ARRAY : SRC_ZERO;
        end else if (wr_acc && RDW_MODE == RDW_OLD) begin
            src_d = SRC_ARRAY;
        end else if (wr_acc && RDW_MODE == RDW_NEW) begin
            src_d   = SRC_MERGE;
            wdata_d = wdata;
            be_d    = be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            rvalid_q <= 1'b0;
            src_q    <= SRC_ZERO;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            src_q    <= src_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    always_comb begin
        merged = arr_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        case (src_q)
            SRC_MERGE: rdata = merged;
            SRC_ZERO:  rdata = '0;
            default:   rdata = arr_rdata;
        endcase
    end

    assign busy   = busy_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sp_ram_clr.sv
// Scoreboard bench for sp_ram_clr: three DEPTH=64 instances (one per RDW mode) and one DEPTH=48 instance.
module tb_sp_ram_clr;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, clr = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [5:0]  addr = 6'd0;
    logic [31:0] wdata = 32'h0;
    logic        req48 = 1'b0, we48 = 1'b0;
    logic [3:0]  be48 = 4'h0;
    logic [5:0]  addr48 = 6'd0;
    logic [31:0] wdata48 = 32'h0;

    logic        ready0, busy0, rvalid0, ready1, busy1, rvalid1, ready2, busy2, rvalid2;
    logic        ready48, busy48, rvalid48;
    logic [31:0] rdata0, rdata1, rdata2, rdata48;

    exp_t exp_q[$];
    exp_t exp48_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_clr #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata), .clr(clr),
        .ready(ready0), .busy(busy0), .rvalid(rvalid0), .rdata(rdata0));
    sp_ram_clr #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata), .clr(clr),
        .ready(ready1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1));
    sp_ram_clr #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .RDW_MODE(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata), .clr(clr),
        .ready(ready2), .busy(busy2), .rvalid(rvalid2), .rdata(rdata2));
    sp_ram_clr #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .RDW_MODE(0)) dut48 (
        .clk(clk), .rst(rst), .req(req48), .we(we48), .be(be48), .addr(addr48), .wdata(wdata48), .clr(1'b0),
        .ready(ready48), .busy(busy48), .rvalid(rvalid48), .rdata(rdata48));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus; sel=1 targets the DEPTH=48 instance.
    task automatic applyStimulus(input logic sel, input logic s_req, input logic s_we, input logic [5:0] s_addr,
                                 input logic [31:0] s_wdata, input logic [3:0] s_be, input logic s_push,
                                 input logic [31:0] s_exp);
        req = 1'b0;
        req48 = 1'b0;
        if (sel) begin
            req48 = s_req; we48 = s_we; addr48 = s_addr; wdata48 = s_wdata; be48 = s_be;
            if (s_push) exp48_q.push_back('{data: s_exp, cyc: cyc + 1});
        end else begin
            req = s_req; we = s_we; addr = s_addr; wdata = s_wdata; be = s_be;
            if (s_push) exp_q.push_back('{data: s_exp, cyc: cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, input logic [5:0] a, input logic [31:0] e);
        applyStimulus(sel, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, e);
    endtask

    task automatic wr(input logic sel, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
        applyStimulus(sel, 1'b1, 1'b1, a, d, b, 1'b0, 32'h0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    // Monitor: every rvalid pops one expected read and checks data and the cycle it arrived in.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rvalid0) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rdata_mode0", rdata0, e.data);
                checkOutput("rd_latency", 32'(cyc), 32'(e.cyc));
                checkOutput("rdata_mode1", rdata1, e.data);
                checkOutput("rdata_mode2", rdata2, e.data);
                checkOutput("rvalid_modes12", {30'd0, rvalid1, rvalid2}, 32'd3);
            end
        end
        if (!rst && rvalid48) begin
            if (exp48_q.size() == 0) begin
                checkOutput("unexpected_rvalid48", 32'd1, 32'd0);
            end else begin
                e = exp48_q.pop_front();
                checkOutput("rdata_d48", rdata48, e.data);
                checkOutput("rd_latency_d48", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int n;
        int n48;
        $display("[TB] start");
        #12;
        checkOutput("reset_ready", {31'd0, ready0}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy0}, 32'd1);
        checkOutput("reset_rvalid", {31'd0, rvalid0}, 32'd0);
        checkOutput("reset_rdata", rdata0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        n48 = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ready48 && n48 == 0) n48 = n;
            if (ready0) break;
        end
        checkOutput("clear_edges_d64", 32'(n), 32'd64);
        checkOutput("clear_edges_d48", 32'(n48), 32'd48);
        checkOutput("busy_after_clear", {31'd0, busy0}, 32'd0);

        for (int i = 0; i < 64; i++) rd(1'b0, 6'(i), 32'h0);
        idle();

        $display("[TB] byte enables");
        wr(1'b0, 6'd5, 32'hAABBCCDD, 4'b1111);
        wr(1'b0, 6'd5, 32'h11223344, 4'b0101);
        rd(1'b0, 6'd5, 32'hAA22CC44);

        $display("[TB] read during write");
        wr(1'b0, 6'd3, 32'h12345678, 4'b1111);
        wr(1'b0, 6'd3, 32'h00000055, 4'b0001);
        checkOutput("rdw_old", rdata0, 32'h12345678);
        checkOutput("rdw_new", rdata1, 32'h12345655);
        checkOutput("rdw_hold", rdata2, 32'hAA22CC44);
        checkOutput("rdw_rvalid", {29'd0, rvalid0, rvalid1, rvalid2}, 32'd0);

        $display("[TB] back-to-back reads");
        wr(1'b0, 6'd0, 32'h10000001, 4'hF);
        wr(1'b0, 6'd1, 32'h20000002, 4'hF);
        wr(1'b0, 6'd2, 32'h30000003, 4'hF);
        rd(1'b0, 6'd0, 32'h10000001);
        rd(1'b0, 6'd1, 32'h20000002);
        rd(1'b0, 6'd2, 32'h30000003);
        idle();

        $display("[TB] clear with coincident read");
        wr(1'b0, 6'd63, 32'hCAFEF00D, 4'hF);
        req = 1'b1; we = 1'b0; addr = 6'd5; clr = 1'b1;
        #1;
        checkOutput("ready_during_clr", {31'd0, ready0}, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0; clr = 1'b0;
        n = 0;
        while (n < 200) begin
            if (!busy0) break;
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("clr_busy_cycles", 32'(n), 32'd64);
        checkOutput("ready_after_clr", {31'd0, ready0}, 32'd1);
        for (int i = 0; i < 64; i++) rd(1'b0, 6'(i), 32'h0);
        idle();

        $display("[TB] reset during clear");
        wr(1'b0, 6'd10, 32'hCAFEF00D, 4'hF);
        wr(1'b0, 6'd40, 32'h0BADCAFE, 4'hF);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midclr_rst_busy", {31'd0, busy0}, 32'd1);
        checkOutput("midclr_rst_ready", {31'd0, ready0}, 32'd0);
        checkOutput("midclr_rst_rdata", rdata0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ready0) break;
        end
        checkOutput("restart_edges", 32'(n), 32'd64);
        rd(1'b0, 6'd10, 32'h0);
        rd(1'b0, 6'd40, 32'h0);
        idle();

        $display("[TB] out of range, DEPTH=48");
        wr(1'b1, 6'd2, 32'h0BADF00D, 4'hF);
        wr(1'b1, 6'd47, 32'h47474747, 4'hF);
        wr(1'b1, 6'd50, 32'hFFFFFFFF, 4'hF);
        rd(1'b1, 6'd50, 32'h0);
        rd(1'b1, 6'd2, 32'h0BADF00D);
        rd(1'b1, 6'd47, 32'h47474747);
        idle();
        repeat (3) idle();

        checkOutput("pending_reads", 32'(exp_q.size()), 32'd0);
        checkOutput("pending_reads_d48", 32'(exp48_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
